// File: rtl/seq_logic_unit.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR over WIDTH bits, SLICE bits per cycle,
// with a start/busy/done handshake and full-width zero/parity flags.
module seq_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_result;
  logic               r_done;
  logic               r_zero;
  logic               r_parity;

  logic               w_accept;
  logic               w_last;
  logic [SLICE-1:0]   w_sa;
  logic [SLICE-1:0]   w_sb;
  logic [SLICE-1:0]   w_slice;
  logic [WIDTH-1:0]   w_result_nxt;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(N - 1));

  // Slice selection by constant-index compare keeps every part-select static.
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int unsigned s = 0; s < N; s++) begin
      if (r_cnt == CW'(s)) begin
        w_sa = r_a[s*SLICE +: SLICE];
        w_sb = r_b[s*SLICE +: SLICE];
      end
    end
  end

  always_comb begin
    w_slice = '0;
    case (r_op)
      2'b00:   w_slice = w_sa & w_sb;
      2'b01:   w_slice = w_sa | w_sb;
      2'b10:   w_slice = w_sa ^ w_sb;
      default: w_slice = ~(w_sa | w_sb);
    endcase
  end

  always_comb begin
    w_result_nxt = r_result;
    for (int unsigned s = 0; s < N; s++) begin
      if (r_cnt == CW'(s)) begin
        w_result_nxt[s*SLICE +: SLICE] = w_slice;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_zero   <= 1'b0;
      r_parity <= 1'b0;
    end else begin
      // done is high only for the cycle following the final slice write.
      r_done <= w_last;
      if (w_accept) begin
        r_a      <= a;
        r_b      <= b;
        r_op     <= op;
        r_result <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_RUN) begin
        r_result <= w_result_nxt;
        if (w_last) begin
          r_cnt    <= '0;
          r_zero   <= ~|w_result_nxt;
          r_parity <= ^w_result_nxt;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = r_done;
  assign result = r_result;
  assign zero   = r_zero;
  assign parity = r_parity;

endmodule

// File: doc/seq_logic_unit.md
Name: seq_logic_unit

Overview:
Parametrised multi-cycle bitwise logic unit for the MIPS ALU datapath. It is the successor of the fixed 32-bit XOR block. It supports AND/OR/XOR/NOR over a configurable width and processes SLICE bits per cycle, trading latency for area. It uses a start/busy/done handshake and produces zero and parity flags alongside the result.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SLICE, 8, bits processed per cycle. WIDTH must be a multiple of SLICE. N = WIDTH/SLICE is the number of slice cycles.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted on any rising edge where busy==0.
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
- a  input  WIDTH  operand A; sampled only at acceptance.
- b  input  WIDTH  operand B; sampled only at acceptance.
- busy  output  1  high while slices are being computed.
- done  output  1  one-cycle pulse when the result is complete.
- result  output  WIDTH  registered result; valid from the done pulse until the next acceptance.
- zero  output  1  result==0; valid with result.
- parity  output  1  XOR-reduction of result; valid with result.

Behaviour:
Reset:
- Asynchronous, active-high; asserting reset immediately forces the state to IDLE.
- busy=0, done=0, result=0, zero=0, parity=0, slice counter=0, latched operands/op=0.

States:
- IDLE: busy=0. start=1 at an edge → latch a, b and op; clear result to 0; clear the counter; go to RUN (busy=1). The done pulse, if any, clears on this same edge.
- RUN: busy=1. Each edge writes result[cnt*SLICE +: SLICE] = op(a_slice, b_slice) from the latched operands, then cnt++.
  - On the edge that writes slice N-1: busy=0, done=1, zero and parity update from the final full result, state → IDLE.
  - Any edge leaving done set from a previous cycle clears it, so done is exactly one cycle wide.

Latency:
- Acceptance edge E0 → done high after edge EN, i.e. N cycles after acceptance.
- Earliest next acceptance is E(N+1), so back-to-back throughput is one operation per N+1 cycles.
- SLICE==WIDTH gives N=1: done is high the cycle after acceptance.

Handshake rules:
- start while busy=1 is ignored. It is not queued, and the latched operands and op are unaffected.
- start held high continuously re-triggers at every edge where busy==0.
- Changing a, b or op after acceptance has no effect on the running operation.

Outputs during and after an operation:
- During RUN, result shows partially written slices; the higher slices read 0. zero/parity hold their previous values until done.
- After done, result/zero/parity hold until the next acceptance. At acceptance, result clears to 0; zero/parity keep their old values.

Flags and arithmetic:
- NOR is the bitwise complement of OR, applied per slice.
- No carries and no cross-slice dependency.
- The zero and parity flags are computed over the full WIDTH result, not per slice.

Reset mid-operation:
- Abort immediately; all outputs return to reset values.
- No done pulse is produced for the aborted operation.
- After reset deasserts, the first edge with start=1 is accepted normally.

Test Plan:
1. WIDTH=32, SLICE=8, op=10 (XOR), a=AAAAAAAA, b=55555555, start one cycle → busy for 4 cycles; done pulses at cycle 4; result=FFFFFFFF, zero=0, parity=0.
2. op=10 (XOR), a=b=AAAAAAAA → result=00000000, zero=1, parity=0. Then op=00 (AND), a=FFFF0000, b=0F0F0F0F → result=0F0F0000, zero=0, parity=0.
3. op=11 (NOR), a=0, b=00000001 → result=FFFFFFFE, parity=1. Also check the cycle-1 intermediate result=000000FE, confirming lowest-slice-first fill.
4. Start an op=01 (OR) operation, then pulse start with different operands at cycles 1–3 and change a/b → the first result alone is produced, and no second done appears.
5. Assert reset at cycle 2 of RUN → busy/done/result/flags go to 0 immediately with no done pulse. After release, a new XOR completes correctly.
6. SLICE=32 (N=1) with start held high → done pulses every 2 cycles; each result matches the operands presented at its acceptance edge.
